// File: rtl/conv_input_interface.sv
// Responder side of the conv-layer input command/ack protocol. Fetches image rows from memory
// into KERNEL_SIZE row buffers and streams KERNEL_SIZE x KERNEL_SIZE windows across the band.
module conv_input_interface #(
  parameter int unsigned IMAGE_SIZE  = 8,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 6
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [1:0]                                    input_interface_cmd,
  output logic [1:0]                                    input_interface_ack,
  output logic                                          rd_en,
  output logic [ADDR_WIDTH-1:0]                         rd_addr,
  input  logic [DATA_WIDTH-1:0]                         rd_data,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_data,
  output logic                                          window_valid,
  output logic [2:0]                                    window_col,
  output logic [3:0]                                    row_ptr
);

  // Command / ack encodings shared with the layer controller.
  localparam logic [1:0] CmdIdle       = 2'd0;
  localparam logic [1:0] CmdPreload    = 2'd1;
  localparam logic [1:0] CmdShift      = 2'd2;
  localparam logic [1:0] CmdLoad       = 2'd3;
  localparam logic [1:0] AckIdle       = 2'd0;
  localparam logic [1:0] AckPreloadFin = 2'd1;
  localparam logic [1:0] AckShiftFin   = 2'd2;
  localparam logic [1:0] AckLoadFin    = 2'd3;

  localparam int unsigned OutSize    = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned PreloadLen = KERNEL_SIZE * IMAGE_SIZE;
  localparam int unsigned CntW       = $clog2(PreloadLen + 2);
  localparam int unsigned RowIdxW    = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int unsigned ColIdxW    = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int unsigned WinW       = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;

  localparam logic [CntW-1:0] PreloadEnd   = CntW'(PreloadLen);
  localparam logic [CntW-1:0] PreloadLastRd = CntW'(PreloadLen - 1);
  localparam logic [CntW-1:0] LoadEnd      = CntW'(IMAGE_SIZE);
  localparam logic [CntW-1:0] LoadLastRd   = CntW'(IMAGE_SIZE - 1);
  localparam logic [3:0]      RowEnd       = 4'(IMAGE_SIZE);
  localparam logic [3:0]      BandRows     = 4'(KERNEL_SIZE);
  localparam logic [2:0]      LastCol      = 3'(OutSize - 1);

  typedef enum logic [2:0] {StIdle, StPreload, StShift, StLoad, StAck} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [CntW-1:0]         cap_idx;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [1:0]              ack_q, ack_d;
  logic                    wv_q, wv_d;
  logic [2:0]              wcol_q, wcol_d;
  logic [WinW-1:0]         wdata_q, wdata_d;
  logic [3:0]              row_ptr_q, row_ptr_d;
  logic [DATA_WIDTH-1:0]   buf_q [KERNEL_SIZE][IMAGE_SIZE];
  logic [DATA_WIDTH-1:0]   buf_d [KERNEL_SIZE][IMAGE_SIZE];
  logic [DATA_WIDTH-1:0]   stage_q [IMAGE_SIZE];
  logic [DATA_WIDTH-1:0]   stage_d [IMAGE_SIZE];
  logic                    win_load;
  logic [2:0]              win_sel;
  logic [WinW-1:0]         win_next;

  // Read data lags the strobe by one cycle, so cycle n captures the pixel issued at n-1.
  assign cap_idx = cnt_q - 1'b1;

  // Window gather: columns win_sel..win_sel+K-1 of every row buffer, row 0 oldest.
  always_comb begin
    win_next = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        win_next[(r*KERNEL_SIZE+c)*DATA_WIDTH +: DATA_WIDTH] =
            buf_q[RowIdxW'(r)][ColIdxW'(int'(win_sel) + c)];
      end
    end
  end

  // Next-state and registered-output logic for the command FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    ack_d     = AckIdle;
    wv_d      = 1'b0;
    wcol_d    = wcol_q;
    win_load  = 1'b0;
    win_sel   = '0;
    row_ptr_d = row_ptr_q;
    buf_d     = buf_q;
    stage_d   = stage_q;

    unique case (state_q)
      StIdle: begin
        unique case (input_interface_cmd)
          CmdIdle: ;
          CmdPreload: begin
            state_d   = StPreload;
            cnt_d     = '0;
            row_ptr_d = '0;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
          end
          CmdShift: begin
            state_d  = StShift;
            wv_d     = 1'b1;
            wcol_d   = '0;
            win_load = 1'b1;
            win_sel  = '0;
          end
          CmdLoad: begin
            if (row_ptr_q == RowEnd) begin
              // Frame exhausted: acknowledge without touching memory or buffers.
              state_d = StAck;
              ack_d   = AckLoadFin;
            end else begin
              state_d   = StLoad;
              cnt_d     = '0;
              rd_en_d   = 1'b1;
              rd_addr_d = ADDR_WIDTH'(row_ptr_q * IMAGE_SIZE);
            end
          end
          default: ;
        endcase
      end

      StPreload: begin
        if (cnt_q < PreloadLastRd) begin
          rd_en_d   = 1'b1;
          rd_addr_d = ADDR_WIDTH'(cnt_q + 1'b1);
        end
        if (cnt_q != '0) begin
          buf_d[RowIdxW'(cap_idx / IMAGE_SIZE)][ColIdxW'(cap_idx % IMAGE_SIZE)] = rd_data;
        end
        if (cnt_q == PreloadEnd) begin
          state_d   = StAck;
          ack_d     = AckPreloadFin;
          row_ptr_d = BandRows;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StShift: begin
        if (wcol_q == LastCol) begin
          state_d = StAck;
          ack_d   = AckShiftFin;
        end else begin
          wv_d     = 1'b1;
          wcol_d   = wcol_q + 3'd1;
          win_load = 1'b1;
          win_sel  = wcol_q + 3'd1;
        end
      end

      StLoad: begin
        if (cnt_q < LoadLastRd) begin
          rd_en_d   = 1'b1;
          rd_addr_d = ADDR_WIDTH'(row_ptr_q * IMAGE_SIZE + cnt_q + 1'b1);
        end
        if (cnt_q == LoadEnd) begin
          // Row complete: scroll the band up and append the staged row (last pixel bypassed).
          for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
            buf_d[RowIdxW'(r)] = buf_q[RowIdxW'(r + 1)];
          end
          buf_d[RowIdxW'(KERNEL_SIZE - 1)] = stage_q;
          buf_d[RowIdxW'(KERNEL_SIZE - 1)][ColIdxW'(IMAGE_SIZE - 1)] = rd_data;
          state_d   = StAck;
          ack_d     = AckLoadFin;
          row_ptr_d = row_ptr_q + 4'd1;
        end else begin
          if (cnt_q != '0) begin
            stage_d[ColIdxW'(cap_idx)] = rd_data;
          end
          cnt_d = cnt_q + 1'b1;
        end
      end

      StAck: state_d = StIdle;

      default: state_d = StIdle;
    endcase

    wdata_d = win_load ? win_next : wdata_q;
  end

  // State and output registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      ack_q     <= AckIdle;
      wv_q      <= 1'b0;
      wcol_q    <= '0;
      wdata_q   <= '0;
      row_ptr_q <= '0;
      buf_q     <= '{default: '0};
      stage_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      ack_q     <= ack_d;
      wv_q      <= wv_d;
      wcol_q    <= wcol_d;
      wdata_q   <= wdata_d;
      row_ptr_q <= row_ptr_d;
      buf_q     <= buf_d;
      stage_q   <= stage_d;
    end
  end

  assign input_interface_ack = ack_q;
  assign rd_en               = rd_en_q;
  assign rd_addr             = rd_addr_q;
  assign window_data         = wdata_q;
  assign window_valid        = wv_q;
  assign window_col          = wcol_q;
  assign row_ptr             = row_ptr_q;

endmodule

// File: tb/tb_conv_input_interface.sv
// Self-checking bench for conv_input_interface: cycle-exact checks against an image/band model.
module tb_conv_input_interface;

  localparam int N   = 8;
  localparam int K   = 3;
  localparam int DW  = 8;
  localparam int AW  = 6;
  localparam int OUT = N - K + 1;
  localparam int WW  = K * K * DW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     cmd = 2'd0;
  logic [1:0]     ack;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  rd_data = '0;
  logic [WW-1:0]  window_data;
  logic           window_valid;
  logic [2:0]     window_col;
  logic [3:0]     row_ptr;

  conv_input_interface #(
    .IMAGE_SIZE (N),
    .KERNEL_SIZE(K),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .input_interface_cmd(cmd),
    .input_interface_ack(ack),
    .rd_en              (rd_en),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data),
    .window_data        (window_data),
    .window_valid       (window_valid),
    .window_col         (window_col),
    .row_ptr            (row_ptr)
  );

  always #5 clk = ~clk;

  // Image memory and the model's view of the row band.
  logic [DW-1:0] mem [N*N];
  logic [DW-1:0] mbuf [K][N];
  int            rp_m;
  int            n_checks = 0;
  int            n_fail = 0;

  // One-cycle read latency memory.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] win_model(input int col);
    logic [127:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DW +: DW] = mbuf[r][col+c];
    return w;
  endfunction

  task automatic model_reset();
    rp_m = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < N; c++) mbuf[r][c] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " rd_en"}, 128'(rd_en), 0);
    check_eq({tag, " rd_addr"}, 128'(rd_addr), 0);
    check_eq({tag, " ack"}, 128'(ack), 0);
    check_eq({tag, " wvalid"}, 128'(window_valid), 0);
    check_eq({tag, " wcol"}, 128'(window_col), 0);
    check_eq({tag, " wdata"}, 128'(window_data), 0);
    check_eq({tag, " row_ptr"}, 128'(row_ptr), 0);
  endtask

  // Starts at a negedge with the DUT idle; presents c for one cycle and checks every cycle
  // through the ack and the cycle after it. inject_at>0 pulses a LOAD command in that cycle.
  task automatic run_cmd(input logic [1:0] c, input int inject_at);
    int nreads, base, nwin, ack_cyc, new_rp;
    logic [1:0] ack_code;
    string t;
    nreads = 0; base = 0; nwin = 0;
    case (c)
      2'd1: begin nreads = K*N; ack_cyc = K*N + 2; ack_code = 2'd1; new_rp = K; end
      2'd2: begin nwin = OUT; ack_cyc = OUT + 1; ack_code = 2'd2; new_rp = rp_m; end
      default: begin
        ack_code = 2'd3;
        if (rp_m == N) begin ack_cyc = 1; new_rp = rp_m; end
        else begin nreads = N; base = rp_m * N; ack_cyc = N + 2; new_rp = rp_m + 1; end
      end
    endcase
    cmd = c;
    for (int k = 1; k <= ack_cyc + 1; k++) begin
      @(negedge clk);
      cmd = (k == inject_at) ? 2'd3 : 2'd0;
      t = $sformatf("cmd%0d rp%0d c%0d", c, rp_m, k);
      check_eq({t, " rd_en"}, 128'(rd_en), 128'(k <= nreads));
      if (k <= nreads) check_eq({t, " rd_addr"}, 128'(rd_addr), 128'(base + k - 1));
      if (nreads > 0 && k == nreads + 1)
        check_eq({t, " rd_addr hold"}, 128'(rd_addr), 128'(base + nreads - 1));
      check_eq({t, " wvalid"}, 128'(window_valid), 128'(k <= nwin));
      if (k <= nwin) begin
        check_eq({t, " wcol"}, 128'(window_col), 128'(k - 1));
        check_eq({t, " wdata"}, 128'(window_data), win_model(k - 1));
      end
      check_eq({t, " ack"}, 128'(ack), (k == ack_cyc) ? 128'(ack_code) : 128'(0));
      if (k == ack_cyc) check_eq({t, " row_ptr"}, 128'(row_ptr), 128'(new_rp));
    end
    // Model update at the level of whole image rows.
    if (c == 2'd1) begin
      for (int r = 0; r < K; r++)
        for (int cc = 0; cc < N; cc++) mbuf[r][cc] = mem[r*N + cc];
    end else if (c == 2'd3 && nreads > 0) begin
      for (int r = 0; r < K - 1; r++) mbuf[r] = mbuf[r+1];
      for (int cc = 0; cc < N; cc++) mbuf[K-1][cc] = mem[rp_m*N + cc];
    end
    rp_m = new_rp;
  endtask

  initial begin
    int sel;
    for (int i = 0; i < N*N; i++) mem[i] = DW'(i);
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Preload, sweep, load, sweep on the advanced band.
    run_cmd(2'd1, 0);
    run_cmd(2'd2, 0);
    run_cmd(2'd3, 0);
    run_cmd(2'd2, 0);

    // Full frame walk; one sweep carries an ignored LOAD pulse.
    run_cmd(2'd1, 0);
    for (int b = 0; b < 6; b++) begin
      for (int s = 0; s < 4; s++) run_cmd(2'd2, (b == 0 && s == 1) ? 3 : 0);
      run_cmd(2'd3, 0);
    end
    check_eq("frame end row_ptr", 128'(row_ptr), 128'(N));

    // Reset in cycle 10 of a preload: immediate clear, no ack afterwards.
    cmd = 2'd1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      cmd = 2'd0;
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("post-reset ack c%0d", k), 128'(ack), 0);
      check_eq($sformatf("post-reset rd_en c%0d", k), 128'(rd_en), 0);
    end
    run_cmd(2'd2, 0);  // cleared buffers give all-zero windows
    run_cmd(2'd1, 0);

    // Randomized traffic over random image contents.
    for (int i = 0; i < N*N; i++) mem[i] = DW'($urandom);
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sel = $urandom_range(0, 9);
      if (sel == 0) run_cmd(2'd1, 0);
      else if (sel < 6) run_cmd(2'd2, ($urandom_range(0, 1) == 1) ? $urandom_range(1, OUT) : 0);
      else run_cmd(2'd3, 0);
      if (it == 30) for (int i = 0; i < N*N; i++) mem[i] = DW'($urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
